// File: rtl/sliced_addsub_seq.sv
// Multi-cycle adder/subtractor: one SLICE-bit slice per clock with a registered carry
// between slices, valid/ready handshakes on both sides, and cout/ovf/zero flags.
module sliced_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_split
    $error("sliced_addsub_seq: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_sum;
  logic             accept;
  logic             last_slice;

  // Operands shift right one slice per RUN cycle, so the active slice is always the low bits.
  assign a_slice    = a_q[SLICE-1:0];
  assign b_slice    = bx_q[SLICE-1:0];
  assign slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
  assign accept     = (state_q == IDLE) && in_valid;
  assign last_slice = (k_q == K_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // NOTE: every variable gets a default at the top of the block so no path leaves it
  // unassigned; that is what keeps this combinational block from inferring latches.
  always_comb begin
    a_d     = a_q;
    bx_d    = bx_q;
    carry_d = carry_q;
    k_d     = k_q;
    x_d     = x_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (accept) begin
      a_d     = A;
      bx_d    = sub ? ~B : B;
      carry_d = sub ? ~cin : cin;
      k_d     = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> SLICE;
      bx_d    = bx_q >> SLICE;
      // Result slices enter from the top; after NSLICE shifts X holds the full sum.
      x_d     = (x_q >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
      carry_d = slice_sum[SLICE];
      if (last_slice) begin
        cout_d = slice_sum[SLICE];
        ovf_d  = (a_slice[SLICE-1] == b_slice[SLICE-1]) &&
                 (slice_sum[SLICE-1] != a_slice[SLICE-1]);
        zero_d = (x_d == '0);
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // NOTE: operand and carry registers are always loaded on accept before being read,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    bx_q    <= bx_d;
    carry_q <= carry_d;
  end

  assign X    = x_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
